// File: rtl/matmul_xcel_row_feeder.sv
// rtl/matmul_xcel_row_feeder.sv - skewed row feeder for the systolic array: weight load, then activation streaming
module matmul_xcel_row_feeder #(
  parameter int BIT_WIDTH = 8,
  parameter int N         = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N*BIT_WIDTH-1:0] i_vec,
  input  logic                   i_is_weight,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [N*BIT_WIDTH-1:0] o_row_data,
  output logic [N-1:0]           o_row_wr_weight_ena,
  output logic [N-1:0]           o_row_valid,
  output logic                   o_weights_loaded,
  output logic                   o_idle,
  output logic                   o_err
);

  localparam int WCW = $clog2(N) + 1;
  localparam logic [WCW-1:0] LAST_W = WCW'(N - 1);

  typedef enum logic {LOAD_W, STREAM} state_t;

  // One skew-pipeline slot for a single row.
  typedef struct packed {
    logic [BIT_WIDTH-1:0] data;
    logic                 wr;
    logic                 vld;
  } entry_t;

  state_t         state, state_next;
  logic [WCW-1:0] wcnt;
  logic           accept;
  logic           inj_vld;
  logic           inj_wr;
  logic           drop;
  logic           wcnt_inc;
  logic           weights_loaded_q;
  logic           err_q;
  logic [N-1:0]   row_busy;

  // The feeder never back-pressures; every offered vector is taken.
  assign o_ready = 1'b1;
  assign accept  = i_valid && o_ready;

  // Decide what the accepted vector becomes: a weight/activation injection or a dropped protocol error.
  always_comb begin
    state_next = state;
    inj_vld    = 1'b0;
    inj_wr     = 1'b0;
    drop       = 1'b0;
    wcnt_inc   = 1'b0;
    if (accept) begin
      case (state)
        LOAD_W: begin
          if (i_is_weight) begin
            inj_vld  = 1'b1;
            inj_wr   = 1'b1;
            wcnt_inc = 1'b1;
            if (wcnt == LAST_W) state_next = STREAM;
          end else begin
            drop = 1'b1;
          end
        end
        STREAM: begin
          if (!i_is_weight) inj_vld = 1'b1;
          else              drop    = 1'b1;
        end
        default: state_next = LOAD_W;
      endcase
    end
  end

  // State, weight count, loaded flag (one cycle behind the state) and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= LOAD_W;
      wcnt             <= '0;
      weights_loaded_q <= 1'b0;
      err_q            <= 1'b0;
    end else begin
      state            <= state_next;
      if (wcnt_inc) wcnt <= wcnt + 1'b1;
      weights_loaded_q <= (state == STREAM);
      err_q            <= err_q | drop;
    end
  end

  // Row r gets an r+1 deep shift register so the array sees a diagonal wavefront.
  for (genvar r = 0; r < N; r++) begin : g_row
    entry_t sr [r+1];
    entry_t inj;
    logic   busy;

    assign inj.data = inj_vld ? i_vec[r*BIT_WIDTH +: BIT_WIDTH] : '0;
    assign inj.wr   = inj_wr;
    assign inj.vld  = inj_vld;

    // Shift the row's skew pipeline; reset flushes every stage to a bubble.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int d = 0; d <= r; d++) sr[d] <= '0;
      end else begin
        sr[0] <= inj;
        for (int d = 1; d <= r; d++) sr[d] <= sr[d-1];
      end
    end

    // Any live entry in this row keeps the feeder from reporting idle.
    always_comb begin
      busy = 1'b0;
      for (int d = 0; d <= r; d++) busy = busy | sr[d].vld;
    end

    assign row_busy[r]                           = busy;
    assign o_row_data[r*BIT_WIDTH +: BIT_WIDTH]  = sr[r].data;
    assign o_row_wr_weight_ena[r]                = sr[r].wr;
    assign o_row_valid[r]                        = sr[r].vld;
  end

  assign o_weights_loaded = weights_loaded_q;
  assign o_err            = err_q;
  assign o_idle           = (state == STREAM) && !(|row_busy);

endmodule

// File: tb/tb_matmul_xcel_row_feeder.sv
// tb/tb_matmul_xcel_row_feeder.sv - self-checking bench for matmul_xcel_row_feeder
module tb_matmul_xcel_row_feeder;

  localparam int BW = 8;
  localparam int N  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [N*BW-1:0]   i_vec;
  logic              i_is_weight;
  logic              i_valid;
  logic              o_ready;
  logic [N*BW-1:0]   o_row_data;
  logic [N-1:0]      o_row_wr_weight_ena;
  logic [N-1:0]      o_row_valid;
  logic              o_weights_loaded;
  logic              o_idle;
  logic              o_err;

  matmul_xcel_row_feeder #(.BIT_WIDTH(BW), .N(N)) dut (
    .clk                 (clk),
    .reset               (reset),
    .i_vec               (i_vec),
    .i_is_weight         (i_is_weight),
    .i_valid             (i_valid),
    .o_ready             (o_ready),
    .o_row_data          (o_row_data),
    .o_row_wr_weight_ena (o_row_wr_weight_ena),
    .o_row_valid         (o_row_valid),
    .o_weights_loaded    (o_weights_loaded),
    .o_idle              (o_idle),
    .o_err               (o_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the last N injected vectors (index 0 = most recent) plus protocol state.
  logic [N*BW-1:0] q_data [N];
  logic            q_wr   [N];
  logic            q_vld  [N];
  bit              m_stream;
  int              m_cnt;
  bit              m_err;
  bit              m_wl;
  bit              checking;

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      q_data[k] = '0;
      q_wr[k]   = 1'b0;
      q_vld[k]  = 1'b0;
    end
    m_stream = 0;
    m_cnt    = 0;
    m_err    = 0;
    m_wl     = 0;
  endtask

  // Row r currently shows row r of the vector injected r+1 cycles ago.
  task automatic model_check();
    logic [N*BW-1:0] ed;
    logic [N-1:0]    ew;
    logic [N-1:0]    ev;
    bit              busy;
    busy = 0;
    for (int r = 0; r < N; r++) begin
      ed[r*BW +: BW] = q_data[r][r*BW +: BW];
      ew[r]          = q_wr[r];
      ev[r]          = q_vld[r];
      busy           = busy | q_vld[r];
    end
    chk("row_data", 64'(o_row_data), 64'(ed));
    chk("row_wr_ena", 64'(o_row_wr_weight_ena), 64'(ew));
    chk("row_valid", 64'(o_row_valid), 64'(ev));
    chk("ready", 64'(o_ready), 64'd1);
    chk("weights_loaded", 64'(o_weights_loaded), 64'(m_wl));
    chk("idle", 64'(o_idle), 64'(m_stream && !busy));
    chk("err", 64'(o_err), 64'(m_err));
  endtask

  task automatic model_update(input bit rst, input bit v, input bit w, input logic [N*BW-1:0] vec);
    logic [N*BW-1:0] nd;
    bit              nw;
    bit              nv;
    if (rst) begin
      model_clear();
      return;
    end
    m_wl = m_stream;
    nd = '0; nw = 0; nv = 0;
    if (v) begin
      if (!m_stream) begin
        if (w) begin
          nd = vec; nw = 1; nv = 1;
          m_cnt++;
          if (m_cnt == N) m_stream = 1;
        end else begin
          m_err = 1;
        end
      end else begin
        if (!w) begin
          nd = vec; nv = 1;
        end else begin
          m_err = 1;
        end
      end
    end
    for (int k = N - 1; k > 0; k--) begin
      q_data[k] = q_data[k-1];
      q_wr[k]   = q_wr[k-1];
      q_vld[k]  = q_vld[k-1];
    end
    q_data[0] = nd;
    q_wr[0]   = nw;
    q_vld[0]  = nv;
  endtask

  // Called just after a falling edge: check what the last rising edge produced, then drive this cycle.
  task automatic tick(input bit rst, input bit v, input bit w, input logic [N*BW-1:0] vec);
    if (checking) model_check();
    reset       = rst;
    i_valid     = v;
    i_is_weight = w;
    i_vec       = vec;
    model_update(rst, v, w, vec);
  endtask

  typedef struct {
    bit              valid;
    bit              isw;
    logic [N*BW-1:0] vec;
    logic [N*BW-1:0] e_data;
    logic [N-1:0]    e_wr;
    logic [N-1:0]    e_vld;
    bit              e_wl;
    bit              e_idle;
    bit              e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit v, input bit w, input logic [31:0] vec, input logic [31:0] ed,
                     input logic [3:0] ew, input logic [3:0] ev, input bit wl, input bit idl, input bit er);
    vec_t t;
    t.valid = v; t.isw = w; t.vec = vec;
    t.e_data = ed; t.e_wr = ew; t.e_vld = ev;
    t.e_wl = wl; t.e_idle = idl; t.e_err = er;
    tbl.push_back(t);
  endtask

  initial begin
    reset = 1'b1; i_valid = 1'b0; i_is_weight = 1'b0; i_vec = '0;
    checking = 0;
    model_clear();

    // Idle after reset, weight load W0..W3, single activation, two activations with a gap, late weight.
    for (int i = 0; i < 10; i++) add(0, 0, 0, 32'h0, 4'h0, 4'h0, 0, 0, 0);
    add(1, 1, 32'h03020100, 32'h00000000, 4'b0000, 4'b0000, 0, 0, 0);
    add(1, 1, 32'h07060504, 32'h00000000, 4'b0001, 4'b0001, 0, 0, 0);
    add(1, 1, 32'h0b0a0908, 32'h00000104, 4'b0011, 4'b0011, 0, 0, 0);
    add(1, 1, 32'h0f0e0d0c, 32'h00020508, 4'b0111, 4'b0111, 0, 0, 0);
    add(0, 0, 32'h0,        32'h0306090c, 4'b1111, 4'b1111, 0, 0, 0);
    add(0, 0, 32'h0,        32'h070a0d00, 4'b1110, 4'b1110, 1, 0, 0);
    add(0, 0, 32'h0,        32'h0b0e0000, 4'b1100, 4'b1100, 1, 0, 0);
    add(0, 0, 32'h0,        32'h0f000000, 4'b1000, 4'b1000, 1, 0, 0);
    add(1, 0, 32'h04030201, 32'h00000000, 4'b0000, 4'b0000, 1, 1, 0);
    add(0, 0, 32'h0,        32'h00000001, 4'b0000, 4'b0001, 1, 0, 0);
    add(0, 0, 32'h0,        32'h00000200, 4'b0000, 4'b0010, 1, 0, 0);
    add(0, 0, 32'h0,        32'h00030000, 4'b0000, 4'b0100, 1, 0, 0);
    add(0, 0, 32'h0,        32'h04000000, 4'b0000, 4'b1000, 1, 0, 0);
    add(1, 0, 32'h14131211, 32'h00000000, 4'b0000, 4'b0000, 1, 1, 0);
    add(0, 0, 32'h0,        32'h00000011, 4'b0000, 4'b0001, 1, 0, 0);
    add(1, 0, 32'h24232221, 32'h00001200, 4'b0000, 4'b0010, 1, 0, 0);
    add(0, 0, 32'h0,        32'h00130021, 4'b0000, 4'b0101, 1, 0, 0);
    add(0, 0, 32'h0,        32'h14002200, 4'b0000, 4'b1010, 1, 0, 0);
    add(0, 0, 32'h0,        32'h00230000, 4'b0000, 4'b0100, 1, 0, 0);
    add(0, 0, 32'h0,        32'h24000000, 4'b0000, 4'b1000, 1, 0, 0);
    add(1, 1, 32'hdeadbeef, 32'h00000000, 4'b0000, 4'b0000, 1, 1, 0);
    add(0, 0, 32'h0,        32'h00000000, 4'b0000, 4'b0000, 1, 1, 1);

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tick(1, 0, 0, '0);
    end
    checking = 1;

    foreach (tbl[i]) begin
      @(negedge clk);
      chk("tbl_data", 64'(o_row_data), 64'(tbl[i].e_data));
      chk("tbl_wr_ena", 64'(o_row_wr_weight_ena), 64'(tbl[i].e_wr));
      chk("tbl_valid", 64'(o_row_valid), 64'(tbl[i].e_vld));
      chk("tbl_wloaded", 64'(o_weights_loaded), 64'(tbl[i].e_wl));
      chk("tbl_idle", 64'(o_idle), 64'(tbl[i].e_idle));
      chk("tbl_err", 64'(o_err), 64'(tbl[i].e_err));
      tick(0, tbl[i].valid, tbl[i].isw, tbl[i].vec);
    end

    // Activation during weight load is dropped and does not count as a weight.
    @(negedge clk); tick(1, 0, 0, '0);
    @(negedge clk);
    chk("rst_wloaded", 64'(o_weights_loaded), 64'd0);
    chk("rst_err", 64'(o_err), 64'd0);
    tick(0, 1, 0, 32'haabbccdd);
    @(negedge clk);
    chk("drop_act_err", 64'(o_err), 64'd1);
    chk("drop_act_valid", 64'(o_row_valid), 64'd0);
    tick(0, 1, 1, 32'h00000001);
    for (int k = 1; k < N; k++) begin
      @(negedge clk); tick(0, 1, 1, 32'(k + 1));
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); tick(0, 0, 0, '0);
    end
    @(negedge clk);
    chk("load_done", 64'(o_weights_loaded), 64'd1);
    tick(0, 1, 0, 32'h0a0b0c0d);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); tick(0, 1, 0, 32'(32'h10203040 + k));
    end
    // Reset with three vectors in flight; the vector offered alongside reset is discarded.
    @(negedge clk); tick(1, 1, 0, 32'h55555555);
    @(negedge clk);
    chk("midrst_data", 64'(o_row_data), 64'd0);
    chk("midrst_valid", 64'(o_row_valid), 64'd0);
    chk("midrst_wloaded", 64'(o_weights_loaded), 64'd0);
    chk("midrst_err", 64'(o_err), 64'd0);
    tick(0, 1, 1, 32'h11223344);
    @(negedge clk);
    chk("postrst_wr", 64'(o_row_wr_weight_ena), 64'b0001);
    chk("postrst_row0", 64'(o_row_data[BW-1:0]), 64'h44);
    tick(0, 0, 0, '0);

    // Random traffic, mostly well-formed, with occasional wrong-type vectors and resets.
    for (int i = 0; i < 600; i++) begin
      bit rst, v, w;
      @(negedge clk);
      rst = ($urandom_range(0, 59) == 0);
      v   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) w = m_stream;
      else                           w = !m_stream;
      tick(rst, v, w, $urandom);
    end

    @(negedge clk);
    model_check();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_xcel_row_feeder.md
Name: matmul_xcel_row_feeder

Overview:
Upstream feeder for the left edge of the weight-stationary systolic array.
- Accepts N-element vectors through a valid/ready handshake and drives each array row's data input and weight-write-enable input.
- Applies the diagonal skew: row r is delayed r extra cycles.
- Sequences a one-time weight-load phase (N weight vectors, column 0 first), then an unbounded activation-streaming phase.
- Produces a per-row skewed valid for the downstream output deskew/collector.

Parameters:
BIT_WIDTH, 8, width of one data element
N, 4, array dimension: number of rows fed, and number of weight vectors loaded

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
i_vec  input  N*BIT_WIDTH  input vector; element r is i_vec[r*BIT_WIDTH +: BIT_WIDTH] and feeds row r
i_is_weight  input  1  1 = vector holds weights, 0 = vector holds activations
i_valid  input  1  input vector valid
o_ready  output  1  feeder can accept a vector
o_row_data  output  N*BIT_WIDTH  per-row data into PE column 0, same packing as i_vec
o_row_wr_weight_ena  output  N  per-row weight-write enable into PE column 0
o_row_valid  output  N  per-row skewed valid, for the downstream collector
o_weights_loaded  output  1  high once all N weight vectors have been accepted
o_idle  output  1  in STREAM state and no valid entry anywhere in the skew pipeline
o_err  output  1  sticky protocol-error flag

Behaviour:
- Accept: a vector is accepted in a cycle where i_valid && o_ready. o_ready = 1 in every state after reset; the feeder never stalls.
- FSM states: LOAD_W (reset state) and STREAM.
- Weight counter: wcnt, width clog2(N)+1.
- LOAD_W:
  - Accepted vector with i_is_weight=1 is injected with wr_ena=1 and wcnt increments.
  - On the accept with wcnt==N-1, the next state is STREAM.
  - Accepted vector with i_is_weight=0 is dropped: nothing injected, o_err set, wcnt unchanged.
- STREAM:
  - Accepted vector with i_is_weight=0 is injected with wr_ena=0.
  - Accepted vector with i_is_weight=1 is dropped and sets o_err. PE weights are write-once until reset.
  - No exit except reset.
- Injection entry: {data=i_vec, wr_ena, valid=1}.
- Bubble entry: {data=0, wr_ena=0, valid=0}. Inserted whenever nothing is injected (no accept, or a dropped vector).
- Skew: row r outputs are registered and carry row r of the entry injected r+1 cycles earlier.
  - Row 0 latency is 1 cycle; row N-1 latency is N cycles.
  - Implemented as a per-row shift register of depth r+1.
- Weight ordering: the k-th accepted weight vector (k=0..N-1) lands in array column k. The first PE keeps the first enabled word and forwards later ones.
- o_row_wr_weight_ena[r] and o_row_data[r] always move together through the skew; o_row_valid[r] travels in the same entry.
- o_weights_loaded = (state==STREAM), registered.
- o_idle = (state==STREAM) && no valid bit set in any skew stage.
- o_err: sticky; cleared only by reset.
- Reset (any cycle, including mid-load or mid-stream) forces the following on the next edge:
  - all skew stages to bubble;
  - o_row_data=0, o_row_wr_weight_ena=0, o_row_valid=0;
  - state=LOAD_W, wcnt=0, o_weights_loaded=0, o_err=0, o_idle=0.
  - The array shares the same reset, so its weights clear consistently.
- Simultaneous events: reset has priority over an accept in the same cycle; that vector is discarded.

Test Plan:
1. Reset, then hold i_valid=0 for 10 cycles -> all outputs 0; o_ready=1; o_idle=0; o_err=0.
2. N=4, weight vectors W0..W3 with i_vec={4k+3,4k+2,4k+1,4k} accepted back-to-back at cycles t..t+3:
   - row 0 shows data 0,4,8,12 with wr_ena=1 at t+1..t+4;
   - row 3 shows 3,7,11,15 at t+4..t+7;
   - o_weights_loaded=1 from t+5.
3. In STREAM, activation {4,3,2,1} accepted at cycle t -> row0=1 at t+1, row1=2 at t+2, row2=3 at t+3, row3=4 at t+4; wr_ena=0; o_row_valid one-hot diagonal.
4. Activations accepted at t and t+2 with i_valid=0 at t+1 -> every row shows a valid=0, data=0 slot between the two vectors; o_idle=1 from t+7 (last injection at t+2 exits row 3 at t+6).
5. Activation vector sent during LOAD_W -> dropped: no injection, wcnt unchanged, o_err=1. Weight vector sent during STREAM -> dropped, o_err stays 1.
6. Reset asserted mid-stream with 3 vectors in flight -> next cycle all row outputs 0, o_weights_loaded=0, o_err=0. A following weight vector is injected with wr_ena=1.
